ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send direction paired with the existing PS/2 keyboard receiver.
- Takes one command byte through a valid/ready handshake, for example 0xED (set LEDs) or 0xFF (reset).
- Runs the host request-to-send sequence on open-drain ps2_clk/ps2_data, shifts out 8 data bits, odd parity and stop, then checks the device ACK.
- Sits beside the receiver on the same shared PS/2 lines; the top level gates the receiver's sampling with busy.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 1000000: maximum clk cycles from releasing ps2_clk to seeing the stop-bit ACK; 20 ms at 50 MHz.

Ports:
- clk  in  1  system clock
- clrn  in  1  reset; asynchronous assert, active-low
- ps2_clk  in  1  sensed PS/2 clock line, asynchronous to clk
- ps2_data  in  1  sensed PS/2 data line, asynchronous to clk
- tx_data  in  8  byte to send
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE; a byte is accepted on a cycle where tx_valid && tx_ready
- ps2_clk_low  out  1  1 = pull ps2_clk low; 0 = release
- ps2_data_low  out  1  1 = pull ps2_data low; 0 = release
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transfer ends, whether it succeeded or failed
- ack_err  out  1  high together with done when the ACK bit was sampled high
- timeout  out  1  high together with done when TIMEOUT_CYCLES expired

Behaviour:
- Reset values, asynchronous on clrn=0, all registers:
  - state=IDLE, tx_ready=1, busy=0, done=0, ack_err=0, timeout=0.
  - ps2_clk_low=0, ps2_data_low=0 (both lines released).
  - Synchronizer flops = 3'b111.
  - Reset mid-transfer releases both lines immediately and abandons the byte. No done is produced.
- Edge detection:
  - ps2_clk passes through a 3-flop synchronizer.
  - fall = sync[2] & ~sync[1].
  - ps2_data passes through a 2-flop synchronizer.
- Accept: on tx_valid && tx_ready, latch shift = {odd parity = ~^tx_data, tx_data}, bit_cnt=0, go to INHIBIT.
- INHIBIT:
  - ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles.
  - In the last of those cycles, also assert ps2_data_low=1 (start bit).
  - Then go to RTS.
- RTS:
  - ps2_clk_low=0, ps2_data_low=1; timeout counter cleared.
  - On each fall:
    - bit_cnt 0..8: drive ps2_data_low = ~shift[bit_cnt], bit 0 first, parity at bit_cnt 8. Increment bit_cnt.
    - bit_cnt 9: release data (stop bit = 1), go to ACK.
- ACK: on the next fall, sample synced ps2_data. Low means OK; high sets the ack_err flag. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced ps2_clk and ps2_data are both 1.
  - Then pulse done for one cycle with the ack_err value, return to IDLE, raise tx_ready.
- Timeout:
  - A counter runs in RTS, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1: release both lines, pulse done+timeout for one cycle, go to IDLE.
  - Timeout takes priority over a fall in the same cycle.
- Signal rules:
  - Data changes only on falls; outputs are registered.
  - done, ack_err and timeout are never asserted outside the done cycle.
- Boundaries:
  - tx_valid held continuously: the next byte is accepted on the cycle after done, one byte per transfer.
  - tx_data changes after accept do not affect the frame.
  - A fall during INHIBIT is ignored: clk is driven low, so any edge is glitch or skew.
  - No device present: completes with timeout after TIMEOUT_CYCLES.
- Counters: inhibit and timeout share one counter sized $clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES)); bit_cnt is 4 bits.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA.
- Sub-module ps2_edge_sync:
  - 3-flop synchronizer plus falling-edge pulse;
  - shared with the receiver so both ends sample ps2_clk identically.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs:
  - ps2_clk_low holds for exactly INHIBIT_CYCLES;
  - bits seen on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done=1 with ack_err=0; tx_ready returns to 1.
- Send 0xF4 and 0x00: parity bits seen are 0 and 1 respectively.
- Device leaves data high on the ACK clock: done=1, ack_err=1, timeout=0.
- No device clocks: after TIMEOUT_CYCLES, done=1, timeout=1, both drive outputs 0.
- clrn pulsed low during bit 4:
  - ps2_clk_low=0, ps2_data_low=0 and tx_ready=1 within the reset;
  - no done; the next 0xFF transfer completes normally.
- tx_valid held high with 0xEE then 0xFF: two complete back-to-back frames, two done pulses, each accept exactly one cycle after the previous done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command bytes
// and the odd-parity helper used when framing a byte.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        ACK       = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // Parity bit that makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Three-flop synchronizer for an asynchronous PS/2 line with a falling-edge
// pulse; the receiver uses the same block so both sample ps2_clk identically.
module ps2_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], line_i};
        end
    end

    assign level_o = sync_q[1];
    assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits, odd parity,
// stop, then the device ACK, driving the shared lines open-drain style.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          ps2_clk_low,
    output logic          ps2_data_low,
    output logic          busy,
    output logic          done,
    output logic          ack_err,
    output logic          timeout,
    output ps2_tx_state_e state_dbg
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ack_err_q;
    logic             timeout_q;
    logic             clk_low_q;
    logic             data_low_q;
    logic             ack_bad_q;
    logic [8:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       data_sync_q;

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;

    ps2_edge_sync u_clk_sync (
        .clk_i   (clk),
        .rst_ni  (clrn),
        .line_i  (ps2_clk),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign data_lvl = data_sync_q[1];

    // Handshake: a byte transfers on a cycle where tx_valid && tx_ready; tx_ready
    // is high only in IDLE and drops the cycle after accept. tx_data need only be
    // stable in the accept cycle. tx_ready rises one cycle after the done pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            ack_bad_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        shift_q    <= {odd_parity(tx_data), tx_data};
                        bit_cnt_q  <= '0;
                        cnt_q      <= '0;
                        ack_bad_q  <= 1'b0;
                        clk_low_q  <= 1'b1;
                        data_low_q <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= INHIBIT;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end

                // Device clock edges are ignored here: we hold the clock low ourselves.
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= RTS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == INH_START) begin
                            data_low_q <= 1'b1;
                        end
                    end
                end

                RTS, ACK, WAIT_IDLE: begin
                    if (cnt_q == TMO_LAST) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        done_q     <= 1'b1;
                        timeout_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (state_q == RTS && clk_fall) begin
                            if (bit_cnt_q == 4'd9) begin
                                data_low_q <= 1'b0;
                                state_q    <= ACK;
                            end else begin
                                data_low_q <= ~shift_q[bit_cnt_q];
                                bit_cnt_q  <= bit_cnt_q + 4'd1;
                            end
                        end else if (state_q == ACK && clk_fall) begin
                            ack_bad_q <= data_lvl;
                            state_q   <= WAIT_IDLE;
                        end else if (state_q == WAIT_IDLE && clk_lvl && data_lvl) begin
                            done_q    <= 1'b1;
                            ack_err_q <= ack_bad_q;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end

                default: begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;
    assign timeout      = timeout_q;
    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign state_dbg    = state_q;

endmodule
